// File: rtl/cr_axi4s_dp_tx_pkg.sv
// Shared stream types and transmit-side framing definitions.
// The bus structs live in cr_structs; framing constants and write states live in cr_axi4s_dpPKG.
package cr_structs;

    typedef struct packed {
        logic        tvalid;
        logic        tlast;
        logic        tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage

package cr_axi4s_dpPKG;

    localparam int unsigned SOF_BIT = 0;
    localparam int unsigned EOF_BIT = 1;

    typedef enum logic {S_IDLE, S_FRAME} tx_state_e;

endpackage

// File: rtl/cr_axi4s_dp_tx_if.sv
// Producer-side beat interface: simple valid/ready with data, strobes, last, id and user bits.
interface cr_axi4s_dp_tx_if;

    logic        tx_wr_valid;
    logic        tx_wr_ready;
    logic [63:0] tx_wr_data;
    logic [7:0]  tx_wr_strb;
    logic        tx_wr_last;
    logic        tx_wr_tid;
    logic [5:0]  tx_wr_tuser;

    modport master (
        output tx_wr_valid, tx_wr_data, tx_wr_strb, tx_wr_last, tx_wr_tid, tx_wr_tuser,
        input  tx_wr_ready
    );

    modport slave (
        input  tx_wr_valid, tx_wr_data, tx_wr_strb, tx_wr_last, tx_wr_tid, tx_wr_tuser,
        output tx_wr_ready
    );

endinterface

// File: rtl/cr_axi4s_dp_tx_fifo.sv
// Beat buffer for the transmit datapath: storage, wrapping pointers and occupancy.
// Flush clears every entry; callers never push when full or pop when empty.
module cr_axi4s_dp_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 83
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    input  logic [WIDTH-1:0]              wdata_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
    output logic                          empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop_i && !push_i) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cr_axi4s_dp_tx.sv
// Transmit stream source: frames producer beats with SOF/EOF tuser markers, buffers them and
// presents them from a registered head stage honouring tready; reports stats and framing errors.
module cr_axi4s_dp_tx
    import cr_structs::*;
    import cr_axi4s_dpPKG::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned FRAME_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cr_axi4s_dp_tx_if.slave        wr,
    input  logic                   tx_flush,
    output axi4s_dp_bus_t          tx_ob_out,
    input  axi4s_dp_rdy_t          tx_ob_in,
    output logic                   tx_stat_beat,
    output logic                   tx_stat_frame,
    output logic [FRAME_CNT_W-1:0] tx_frame_cnt,
    output logic                   tx_err,
    input  logic                   tx_err_clr
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BeatW = $bits(axi4s_dp_bus_t);

    tx_state_e             state_q;
    axi4s_dp_bus_t         hd_q, beat;
    logic                  wr_ready_q, err_q, stat_beat_q, stat_frame_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic                  accept, xfer, hd_free, bypass, fifo_push, fifo_pop, fifo_empty;
    logic                  err_set, hd_valid_nxt;
    logic [CntW-1:0]       fifo_cnt, fifo_cnt_nxt, occ_nxt;
    logic [BeatW-1:0]      fifo_rdata;

    always_comb begin
        beat                 = '0;
        beat.tvalid          = 1'b1;
        beat.tlast           = wr.tx_wr_last;
        beat.tid             = wr.tx_wr_tid;
        beat.tstrb           = wr.tx_wr_strb;
        beat.tdata           = wr.tx_wr_data;
        beat.tuser[7:2]      = wr.tx_wr_tuser;
        beat.tuser[SOF_BIT]  = (state_q == S_IDLE);
        beat.tuser[EOF_BIT]  = wr.tx_wr_last;
    end

    assign accept  = wr.tx_wr_valid & wr_ready_q;
    assign xfer    = hd_q.tvalid & tx_ob_in.tready;
    assign hd_free = ~hd_q.tvalid | tx_ob_in.tready;

    // An empty buffer lets a new beat go straight to the head for single-cycle latency.
    assign bypass    = accept & ~tx_flush & fifo_empty & hd_free;
    assign fifo_push = accept & ~tx_flush & ~bypass;
    assign fifo_pop  = hd_free & ~fifo_empty & ~tx_flush;

    assign err_set = accept & (wr.tx_wr_last ? (wr.tx_wr_strb == 8'h00)
                                             : (wr.tx_wr_strb != 8'hff));

    // Capacity counts the head stage, so ready tracks every beat the block holds.
    assign fifo_cnt_nxt = tx_flush ? '0 : fifo_cnt + CntW'(fifo_push) - CntW'(fifo_pop);
    assign hd_valid_nxt = bypass | fifo_pop | (hd_q.tvalid & ~tx_ob_in.tready);
    assign occ_nxt      = fifo_cnt_nxt + CntW'(hd_valid_nxt);

    cr_axi4s_dp_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (BeatW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (tx_flush),
        .wdata_i (beat),
        .rdata_o (fifo_rdata),
        .cnt_o   (fifo_cnt),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hd_q         <= '0;
            wr_ready_q   <= 1'b0;
            err_q        <= 1'b0;
            stat_beat_q  <= 1'b0;
            stat_frame_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            if (tx_flush) begin
                state_q <= S_IDLE;
            end else if (accept) begin
                state_q <= wr.tx_wr_last ? S_IDLE : S_FRAME;
            end

            if (fifo_pop) begin
                hd_q <= axi4s_dp_bus_t'(fifo_rdata);
            end else if (bypass) begin
                hd_q <= beat;
            end else if (xfer) begin
                hd_q.tvalid <= 1'b0;
            end

            wr_ready_q   <= (occ_nxt < CntW'(FIFO_DEPTH));
            err_q        <= err_set | (err_q & ~tx_err_clr);
            stat_beat_q  <= xfer;
            stat_frame_q <= xfer & hd_q.tlast;
            if (xfer && hd_q.tlast && !(&frame_cnt_q)) begin
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    assign wr.tx_wr_ready = wr_ready_q;
    assign tx_ob_out      = hd_q;
    assign tx_stat_beat   = stat_beat_q;
    assign tx_stat_frame  = stat_frame_q;
    assign tx_frame_cnt   = frame_cnt_q;
    assign tx_err         = err_q;

endmodule

// File: doc/cr_axi4s_dp_tx.md
Name: cr_axi4s_dp_tx

Overview:
- Transmit-side AXI4-stream datapath source that drives an axi4s_dp_bus_t/axi4s_dp_rdy_t pair into a stream consumer such as a prefix-engine ingress port.
- Accepts beats from a simple valid/ready producer interface and buffers them in a small FIFO.
- Inserts start/end-of-frame tuser markers and drives a fully registered stream output that honours tready backpressure.
- Reports beat/frame statistics and framing errors for the stats and interrupt logic.

Parameters:
- FIFO_DEPTH, 4, number of buffered beats; power of two, at least 2.
- FRAME_CNT_W, 32, width of the saturating frame counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset; one clock, asynchronous active-low reset
- tx_wr_valid  input  1  producer beat valid
- tx_wr_ready  output  1  producer beat accepted when valid&ready
- tx_wr_data  input  64  beat data
- tx_wr_strb  input  8  byte strobes
- tx_wr_last  input  1  last beat of frame
- tx_wr_tid  input  1  stream id
- tx_wr_tuser  input  6  user bits passed to tuser[7:2]
- tx_flush  input  1  drop buffered, not-yet-presented beats
- tx_ob_out  output  axi4s_dp_bus_t  stream out (tvalid, tlast, tid, tstrb, tuser, tdata)
- tx_ob_in  input  axi4s_dp_rdy_t  stream tready from consumer
- tx_stat_beat  output  1  pulse per output beat transferred
- tx_stat_frame  output  1  pulse per tlast beat transferred
- tx_frame_cnt  output  FRAME_CNT_W  frames transferred, saturating
- tx_err  output  1  sticky framing error
- tx_err_clr  input  1  clears tx_err

Behaviour:
- Reset: all outputs 0; FIFO empty; write state S_IDLE; tx_wr_ready rises the first cycle after reset deasserts.
- FIFO:
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
  - tx_wr_ready = !full, a flop-derived term with no combinational path from tready.
  - When full, there is no same-cycle pop credit: a simultaneous pop does not raise tx_wr_ready that cycle.
- Output registers:
  - tx_ob_out comes from a head register that loads from the FIFO.
  - tvalid is asserted the cycle after a write into an empty block (1-cycle latency).
  - Throughput is one beat per cycle when tready is held high.
- AXI rule: once tvalid=1, tdata/tstrb/tlast/tid/tuser hold stable until tvalid&tready.
- Write-side state machine (advances on each accepted write):
  - S_IDLE to S_FRAME when !last.
  - S_IDLE stays in S_IDLE when last (single-beat frame).
  - S_FRAME to S_IDLE when last.
- tuser construction: tuser[0]=1 when the beat is accepted in S_IDLE (SOF); tuser[1]=tx_wr_last (EOF); tuser[7:2]=tx_wr_tuser.
- Errors:
  - A non-last beat with strb!=8'hff sets tx_err.
  - A last beat with strb==0 sets tx_err.
  - The beat is still forwarded in both cases.
  - If tx_err_clr and a new error occur in the same cycle, set wins.
- Flush:
  - tx_flush empties all FIFO entries next cycle and forces S_IDLE.
  - A beat already presented on tvalid is NOT dropped; it remains until tready.
  - A write accepted in the same cycle as tx_flush is dropped.
- Stats:
  - tx_stat_beat and tx_stat_frame are registered pulses, one cycle after the transfer.
  - tx_frame_cnt increments on each tlast transfer and saturates at all-ones.
- Simultaneous push and pop at occupancy 0<n<FIFO_DEPTH: occupancy is unchanged.

Decomposition:
- Shared package cr_axi4s_dpPKG holds:
  - SOF_BIT=0 and EOF_BIT=1 constants;
  - enum tx_state_e {S_IDLE, S_FRAME}.
- axi4s_dp_bus_t and axi4s_dp_rdy_t stay in cr_structs.
- One sub-module is natural: cr_axi4s_dp_tx_fifo (storage, pointers, occupancy, full/empty).
- Framing, head register, errors and stats stay in cr_axi4s_dp_tx.

Test Plan:
- Single-beat frame:
  - Stimulus: write data=64'h1122334455667788, strb=8'hff, last=1, tready=1.
  - Expected: tvalid 1 cycle later; tuser[1:0]=2'b11; tx_stat_frame pulse; tx_frame_cnt=1.
- 3-beat frame with tready held 0 for 10 cycles:
  - Expected: first beat's fields are stable throughout.
  - With FIFO_DEPTH=4, tx_wr_ready stays 1 after all 3 writes.
  - tuser[1:0] sequence is 01, 00, 10.
- Back-to-back writes with tready=0:
  - Expected: tx_wr_ready drops after 4 accepts.
  - Release tready: 4 beats in 4 consecutive cycles; ready returns the next cycle.
- Flush with 3 queued beats while head tvalid=1, tready=0:
  - Expected: after tready, only the head beat transfers; the FIFO is empty.
  - The next write carries SOF (tuser[0]=1).
- Framing errors:
  - Non-last beat with strb=8'h0f sets tx_err; it stays set until tx_err_clr.
  - A last beat with strb=0 arriving in the same cycle as tx_err_clr leaves tx_err=1.
- Reset mid-frame, asserted asynchronously:
  - Expected: tvalid=0 immediately; all counters 0.
  - After release, the first write is tagged SOF.
